stepgen_quad: RTL and testbench

- Next-generation single-axis step generator for the step-firmware FPGA.
- A fractional velocity is added to a position accumulator each enabled cycle. A carry into bit F of the accumulator requests one output step.
- Adds to the previous generation: synchronous reset, selectable step/dir or quadrature output, a separate dir-hold interval, a step-space interval, and an emitted-step counter for readback.
- Sits between the host register file (velocity, timing, mode) and the output pins.

---
 rtl/stepgen_pkg.sv | 36 +++
 rtl/stepgen_timer.sv | 29 ++
 rtl/stepgen_quad.sv | 168 ++++++++++++++++
 tb/tb_stepgen_quad.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepgen_pkg.sv
// Shared constants for the quadrature-capable step generator: FSM encoding,
// Gray phase table and default geometry.
package stepgen_pkg;

    localparam int W_DEF = 12;
    localparam int F_DEF = 10;
    localparam int T_DEF = 5;
    localparam int C_DEF = 16;

    typedef enum logic [2:0] {
        READY    = 3'd0,
        PULSE    = 3'd1,
        SPACE    = 3'd2,
        DIRHOLD  = 3'd3,
        DIRSETUP = 3'd4
    } state_t;

    // Forward order is PH_0 -> PH_1 -> PH_2 -> PH_3 -> PH_0; {A, B}
    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b01;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b10;

    function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic rev);
        logic [1:0] f;
        logic [1:0] r;
        case (ph)
            PH_0:    begin f = PH_1; r = PH_3; end
            PH_1:    begin f = PH_2; r = PH_0; end
            PH_2:    begin f = PH_3; r = PH_1; end
            default: begin f = PH_0; r = PH_2; end
        endcase
        return rev ? r : f;
    endfunction

endpackage

// File: rtl/stepgen_timer.sv
// Load/decrement interval timer; a load of N gives N+1 cycles until o_zero
// is seen by the state machine.
module stepgen_timer #(
    parameter int T = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [T-1:0] i_val,
    output logic         o_zero
);

    logic [T-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_load)
                r_cnt <= i_val;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - T'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stepgen_quad.sv
// Single-axis step generator: fractional velocity accumulator driving either a
// step/dir output with dir setup/hold timing, or a quadrature A/B output.
module stepgen_quad
    import stepgen_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int F = F_DEF,
    parameter int T = T_DEF,
    parameter int C = C_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_enable,
    input  logic           i_quad,
    input  logic [F:0]     i_velocity,
    input  logic [T-1:0]   i_steptime,
    input  logic [T-1:0]   i_spacetime,
    input  logic [T-1:0]   i_dirtime,
    output logic [W+F-1:0] o_position,
    output logic [C-1:0]   o_count,
    output logic           o_step,
    output logic           o_dir
);

    state_t         r_state;
    state_t         w_next_state;
    logic [W+F-1:0] r_pos;
    logic [C-1:0]   r_count;
    logic           r_step, r_dir, r_dirreg, r_ones, r_mode;
    logic [1:0]     r_phase;

    logic           w_dbit, w_pbit, w_pending, w_reversal, w_mode, w_tzero;
    logic           w_tload, w_issue, w_step_n, w_dir_n, w_dirreg_n;
    logic [T-1:0]   w_tval;
    logic [1:0]     w_phase_adv, w_phase_n;
    logic [W+F-1:0] w_vel_ext;

    assign w_dbit      = i_velocity[F];
    assign w_pbit      = r_pos[F];
    assign w_pending   = (w_pbit != r_ones);
    assign w_reversal  = (r_dirreg != w_dbit);
    assign w_vel_ext   = {{(W-1){i_velocity[F]}}, i_velocity};
    assign w_phase_adv = phase_next(r_phase, r_dirreg);
    // Mode is only taken from the pin in READY; other states use the latched copy.
    assign w_mode      = (r_state == READY) ? i_quad : r_mode;

    stepgen_timer #(.T(T)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_enable),
        .i_load  (w_tload),
        .i_val   (w_tval),
        .o_zero  (w_tzero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= READY;
        else if (i_enable)
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            READY: begin
                if (w_mode) begin
                    if (w_pending) w_next_state = SPACE;
                end else if (w_reversal && !w_pending) begin
                    w_next_state = DIRSETUP;
                end else if (w_pending) begin
                    w_next_state = PULSE;
                end
            end
            PULSE:    if (w_tzero) w_next_state = SPACE;
            SPACE:    if (w_tzero) w_next_state = (!r_mode && w_reversal) ? DIRHOLD : READY;
            DIRHOLD:  if (w_tzero) w_next_state = DIRSETUP;
            DIRSETUP: if (w_tzero) w_next_state = READY;
            default:  w_next_state = READY;
        endcase
    end

    always_comb begin
        w_tload    = 1'b0;
        w_tval     = '0;
        w_issue    = 1'b0;
        w_step_n   = r_step;
        w_dir_n    = r_dir;
        w_dirreg_n = r_dirreg;
        w_phase_n  = r_phase;
        unique case (r_state)
            READY: begin
                // A pending step always goes out first, in the old direction.
                if (w_mode) begin
                    if (w_pending) begin
                        w_issue   = 1'b1;
                        w_phase_n = w_phase_adv;
                        w_step_n  = w_phase_adv[1];
                        w_dir_n   = w_phase_adv[0];
                        w_tload   = 1'b1;
                        w_tval    = i_spacetime;
                    end else if (w_reversal) begin
                        w_dirreg_n = w_dbit;
                    end
                end else if (w_reversal && !w_pending) begin
                    w_dirreg_n = w_dbit;
                    w_dir_n    = w_dbit;
                    w_tload    = 1'b1;
                    w_tval     = i_dirtime;
                end else if (w_pending) begin
                    w_issue  = 1'b1;
                    w_step_n = 1'b1;
                    w_tload  = 1'b1;
                    w_tval   = i_steptime;
                end
            end
            PULSE: if (w_tzero) begin
                w_step_n = 1'b0;
                w_tload  = 1'b1;
                w_tval   = i_spacetime;
            end
            SPACE: if (w_tzero && !r_mode && w_reversal) begin
                w_tload = 1'b1;
                w_tval  = i_dirtime;
            end
            DIRHOLD: if (w_tzero) begin
                w_dirreg_n = w_dbit;
                w_dir_n    = w_dbit;
                w_tload    = 1'b1;
                w_tval     = i_dirtime;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos    <= '0;
            r_count  <= '0;
            r_step   <= 1'b0;
            r_dir    <= 1'b0;
            r_dirreg <= 1'b0;
            r_ones   <= 1'b0;
            r_phase  <= PH_0;
            r_mode   <= 1'b0;
        end else if (i_enable) begin
            // Position stays frozen until the direction change has been accepted.
            if (!w_reversal)
                r_pos <= r_pos + w_vel_ext;
            if (w_issue) begin
                r_ones  <= w_pbit;
                r_count <= r_dirreg ? r_count - C'(1) : r_count + C'(1);
            end
            r_step   <= w_step_n;
            r_dir    <= w_dir_n;
            r_dirreg <= w_dirreg_n;
            r_phase  <= w_phase_n;
            if (r_state == READY)
                r_mode <= i_quad;
        end
    end

    assign o_position = r_pos;
    assign o_count    = r_count;
    assign o_step     = r_step;
    assign o_dir      = r_dir;

endmodule

// File: tb/tb_stepgen_quad.sv
// Bench for stepgen_quad: table of constant-velocity runs checked through a
// scoreboard queue, plus hand-written timing, quadrature, reset and wrap sequences.
module tb_stepgen_quad;

    localparam int W = 12;
    localparam int F = 10;
    localparam int T = 5;
    localparam int C = 16;
    localparam int P = W + F;

    logic           clk = 1'b0;
    logic           reset, enable, quad;
    logic [F:0]     velocity;
    logic [T-1:0]   steptime, spacetime, dirtime;
    logic [P-1:0]   position;
    logic [C-1:0]   count;
    logic           step, dir;

    int             n_pass = 0;
    int             n_total = 0;
    int             cyc = 0;
    logic           mon_on = 1'b0;
    logic           prev_step = 1'b0;
    logic [C-1:0]   prev_count = '0;

    typedef struct {
        logic         q;
        logic [F:0]   v;
        logic [T-1:0] st, sp, dt;
        int           n;
        logic [C-1:0] ec;
        logic [P-1:0] ep;
    } vec_t;

    typedef struct {
        int           idx;
        logic [C-1:0] ec;
        logic [P-1:0] ep;
    } exp_t;

    vec_t       tbl[6];
    exp_t       sb[$];
    logic [1:0] ph_q[$];

    stepgen_quad #(.W(W), .F(F), .T(T), .C(C)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_quad      (quad),
        .i_velocity  (velocity),
        .i_steptime  (steptime),
        .i_spacetime (spacetime),
        .i_dirtime   (dirtime),
        .o_position  (position),
        .o_count     (count),
        .o_step      (step),
        .o_dir       (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    // One active edge; outputs are sampled on the following falling edge.
    task automatic tick();
        logic         rose;
        logic [C-1:0] d;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rose = step & ~prev_step;
        d    = count - prev_count;
        if (mon_on && (rose || d != '0))
            chk("count_vs_rise", 32'(d), rose ? (dir ? 32'h0000FFFF : 32'h1) : 32'h0);
        prev_step  = step;
        prev_count = count;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        int         r1, r2, fl, dch;
        logic       ps, pd, switched, stopped;
        int         post;
        logic [1:0] ph, pph;
        logic [1:0] fwd[8];
        logic [1:0] rev[8];
        exp_t       e;
        logic [1:0] exp_ph;

        reset = 1'b1; enable = 1'b0; quad = 1'b0;
        velocity = '0; steptime = '0; spacetime = '0; dirtime = '0;

        tbl[0] = '{1'b0, 11'h100, 5'd0, 5'd0, 5'd0, 40, 16'd10,   22'h002800};
        tbl[1] = '{1'b0, 11'h080, 5'd2, 5'd2, 5'd0, 64, 16'd8,    22'h002000};
        tbl[2] = '{1'b1, 11'h200, 5'd0, 5'd0, 5'd0, 40, 16'd20,   22'h005000};
        tbl[3] = '{1'b1, 11'h155, 5'd0, 5'd1, 5'd0, 30, 16'd9,    22'h0027F6};
        tbl[4] = '{1'b0, 11'h700, 5'd0, 5'd0, 5'd1, 41, 16'hFFF6, 22'h3FD800};
        tbl[5] = '{1'b1, 11'h700, 5'd0, 5'd0, 5'd0, 20, 16'hFFFB, 22'h3FED00};

        // Reset state
        do_reset();
        enable = 1'b0;
        tick();
        chk("rst_position", 32'(position), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);

        // Constant-velocity runs, drained at zero velocity before comparing
        for (int i = 0; i < 6; i++) begin
            quad = tbl[i].q; velocity = tbl[i].v;
            steptime = tbl[i].st; spacetime = tbl[i].sp; dirtime = tbl[i].dt;
            do_reset();
            sb.push_back('{i, tbl[i].ec, tbl[i].ep});
            repeat (tbl[i].n) tick();
            velocity = '0;
            repeat (16) tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d_count", e.idx), 32'(count), 32'(e.ec));
            chk($sformatf("vec%0d_position", e.idx), 32'(position), 32'(e.ep));
        end

        // First step timing and direction reversal with dir setup/hold
        quad = 1'b0; velocity = 11'h100; steptime = 5'd2; spacetime = 5'd1; dirtime = 5'd3;
        do_reset();
        mon_on = 1'b1;
        r1 = 0; r2 = 0; fl = 0; dch = 0; ps = 1'b0; pd = 1'b0;
        for (int k = 0; k < 40 && r2 == 0; k++) begin
            tick();
            if (step && !ps) begin
                if (r1 == 0) begin
                    r1 = cyc;
                    chk("first_count", 32'(count), 32'h1);
                    chk("first_dir", 32'(dir), 32'h0);
                    velocity = 11'h700;
                end else begin
                    r2 = cyc;
                end
            end
            if (!step && ps && fl == 0) fl = cyc;
            if (dir && !pd && dch == 0) dch = cyc;
            ps = step; pd = dir;
        end
        mon_on = 1'b0;
        chk("first_rise_cycle", 32'(r1), 32'd5);
        chk("first_fall_cycle", 32'(fl), 32'd8);
        chk("dir_change_cycle", 32'(dch), 32'd14);
        chk("second_rise_cycle", 32'(r2), 32'd19);
        chk("dir_after_fall_gap", 32'(dch - fl >= 4), 32'h1);
        chk("rise_after_dir_gap", 32'(r2 - dch >= 4), 32'h1);
        chk("rev_count", 32'(count), 32'h0);
        chk("rev_dir", 32'(dir), 32'h1);

        // Quadrature: 8 forward steps, then reverse back to zero
        fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
        fwd[4] = 2'b01; fwd[5] = 2'b11; fwd[6] = 2'b10; fwd[7] = 2'b00;
        rev[0] = 2'b10; rev[1] = 2'b11; rev[2] = 2'b01; rev[3] = 2'b00;
        rev[4] = 2'b10; rev[5] = 2'b11; rev[6] = 2'b01; rev[7] = 2'b00;
        quad = 1'b1; velocity = 11'h200; steptime = '0; spacetime = '0; dirtime = '0;
        do_reset();
        for (int k = 0; k < 8; k++) ph_q.push_back(fwd[k]);
        pph = 2'b00; switched = 1'b0; stopped = 1'b0; post = 0;
        for (int k = 0; k < 200 && post < 10; k++) begin
            tick();
            ph = {step, dir};
            if (ph != pph) begin
                if (ph_q.size() == 0) begin
                    fail_now($sformatf("quad_extra_phase got %b", ph));
                end else begin
                    exp_ph = ph_q.pop_front();
                    chk("quad_phase", 32'(ph), 32'(exp_ph));
                end
            end
            pph = ph;
            if (!switched && count == 16'd8) begin
                switched = 1'b1;
                velocity = 11'h600;
                for (int j = 0; j < 8; j++) ph_q.push_back(rev[j]);
            end else if (switched && !stopped && count == '0) begin
                stopped  = 1'b1;
                velocity = '0;
            end
            if (stopped) post++;
        end
        chk("quad_phases_left", 32'(ph_q.size()), 32'h0);
        chk("quad_count", 32'(count), 32'h0);

        // Reset mid-pulse (with enable low), then freeze mid-pulse
        quad = 1'b0; velocity = 11'h100; steptime = 5'd2; spacetime = 5'd1; dirtime = '0;
        do_reset();
        for (int k = 0; k < 20 && !step; k++) tick();
        chk("pre_reset_step", 32'(step), 32'h1);
        reset = 1'b1; enable = 1'b0;
        tick();
        chk("midpulse_rst_step", 32'(step), 32'h0);
        chk("midpulse_rst_position", 32'(position), 32'h0);
        chk("midpulse_rst_count", 32'(count), 32'h0);
        reset = 1'b0; enable = 1'b1; cyc = 0; r1 = 0;
        for (int k = 0; k < 20 && r1 == 0; k++) begin
            tick();
            if (step) r1 = cyc;
        end
        chk("post_reset_rise_cycle", 32'(r1), 32'd5);
        enable = 1'b0;
        repeat (10) tick();
        chk("frozen_position", 32'(position), 32'h500);
        chk("frozen_count", 32'(count), 32'h1);
        chk("frozen_step", 32'(step), 32'h1);
        chk("frozen_dir", 32'(dir), 32'h0);
        enable = 1'b1; cyc = 0; fl = 0;
        for (int k = 0; k < 20 && fl == 0; k++) begin
            tick();
            if (!step) fl = cyc;
        end
        chk("resume_fall_cycle", 32'(fl), 32'd3);

        // Cross the accumulator wrap downwards, then back up through zero
        quad = 1'b0; velocity = 11'h700; steptime = '0; spacetime = '0; dirtime = '0;
        do_reset();
        mon_on = 1'b1;
        repeat (9) tick();
        chk("wrap_down_count", 32'(count), 32'h0000FFFE);
        chk("wrap_down_position", 32'(position), 32'h3FF800);
        velocity = 11'h100;
        repeat (8) tick();
        chk("wrap_top_position", 32'(position), 32'h3FFF00);
        tick();
        chk("wrap_zero_position", 32'(position), 32'h0);
        repeat (4) tick();
        velocity = '0;
        repeat (10) tick();
        mon_on = 1'b0;
        chk("wrap_up_count", 32'(count), 32'h1);
        chk("wrap_up_position", 32'(position), 32'h400);
        chk("wrap_up_dir", 32'(dir), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
